// File: rtl/vc_arb_pkg.sv
// rtl/vc_arb_pkg.sv - shared types and bit-vector helpers for the round-robin arbiter
// Purpose: FSM state type plus the prefix-OR and one-hot-to-index helpers used by
//          the grant picker. The helpers work on a fixed maximum width. Callers
//          zero-extend their vectors into that width and size-cast the result back.
// Ports:   none (package)
package vc_arb_pkg;

    localparam int ARB_MAX_REQ = 64;
    localparam int ARB_IDX_W   = 6;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    // Inclusive prefix-OR: t[i] = |v[i:0]
    function automatic logic [ARB_MAX_REQ-1:0] prefix_or(input logic [ARB_MAX_REQ-1:0] v);
        logic [ARB_MAX_REQ-1:0] t;
        t[0] = v[0];
        for (int i = 1; i < ARB_MAX_REQ; i++) begin
            t[i] = t[i-1] | v[i];
        end
        return t;
    endfunction

    // OR of the indices of all set bits; exact for a one-hot input, 0 for all-zero
    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin pick of the lowest request at or above ptr
// Purpose: choose the lowest set request bit at index >= ptr, wrapping to the
//          lowest set bit overall when nothing at or above ptr is requesting.
// Ports:   req    [N_REQ-1:0]  candidate request vector
//          ptr    [IDX_W-1:0]  priority pointer (highest-priority index)
//          onehot [N_REQ-1:0]  one-hot winner, 0 when no request
//          idx    [IDX_W-1:0]  binary index of the winner, 0 when no request
//          any                 at least one request present
module rr_arb_pick
    import vc_arb_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] therm_m;
    logic [N_REQ-1:0] therm_r;
    logic [N_REQ-1:0] oh_m;
    logic [N_REQ-1:0] oh_r;

    // mask = ~((1<<ptr)-1): keep bits at or above the pointer
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (IDX_W'(i) >= ptr);
        end
    end

    assign masked  = req & mask;
    assign therm_m = N_REQ'(prefix_or(ARB_MAX_REQ'(masked)));
    assign therm_r = N_REQ'(prefix_or(ARB_MAX_REQ'(req)));

    // The first 1 of a thermometer code is the lowest set bit of its source
    assign oh_m = therm_m & ~(therm_m << 1);
    assign oh_r = therm_r & ~(therm_r << 1);

    assign onehot = (|masked) ? oh_m : oh_r;
    assign idx    = IDX_W'(onehot2idx(ARB_MAX_REQ'(onehot)));
    assign any    = |req;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - work-conserving round-robin arbiter with hold timeout
// Purpose: registered one-hot grant over N_REQ requesters. A grant is held until
//          the owner releases it, the owner drops its request, or MAX_HOLD cycles
//          have passed (0 = no limit). Handover to another requester takes no
//          idle cycle.
// Ports:   clk, rst_n (async active-low)
//          req         [N_REQ-1:0]  request vector
//          release_i                owner finished (single-cycle pulse)
//          grant       [N_REQ-1:0]  registered one-hot grant
//          grant_valid              grant is non-zero
//          grant_idx   [IDX_W-1:0]  binary index of the grant, 0 when idle
module rr_arbiter
    import vc_arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     release_i,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    // Saturation value; with no limit the counter just parks at all-ones
    localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}}
                                                             : HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  cand_req;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    // Excluding the current owner lets one picker serve both IDLE (grant_q is 0)
    // and handover from GRANTED.
    assign cand_req = req & ~grant_q;

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (cand_req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    logic             owner_req;
    logic             timeout;
    logic             rel;
    logic             load;
    logic [N_REQ-1:0] load_oh;
    logic [IDX_W-1:0] load_idx;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        load     = 1'b0;
        load_oh  = pick_oh;
        load_idx = pick_idx;

        owner_req = req[idx_q];
        timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
        rel       = release_i | ~owner_req | timeout;

        case (state_q)
            ARB_IDLE: begin
                load = pick_any;
            end
            ARB_GRANTED: begin
                if (rel) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else if (owner_req) begin
                        // Nobody else waiting: re-grant the owner and restart its hold window
                        load     = 1'b1;
                        load_oh  = grant_q;
                        load_idx = idx_q;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase

        if (load) begin
            state_d = ARB_GRANTED;
            grant_d = load_oh;
            idx_d   = load_idx;
            hold_d  = '0;
            // Winner drops to lowest priority
            ptr_d   = (load_idx == IDX_W'(N_REQ - 1)) ? '0 : load_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_valid_match   : assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant_q));
    a_idx_match     : assert property (@(posedge clk) disable iff (!rst_n) !grant_valid || grant_q[idx_q]);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter against a behavioural model
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       release_i = 1'b0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner index (-1 = idle), rotating priority, cycles held
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    // First requester at or after p, scanning circularly
    function automatic int rr_pick(logic [3:0] r, int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
        end else begin : model_step
            int         winner;
            logic [3:0] others;
            winner = -1;
            if (m_owner < 0) begin
                winner = rr_pick(req, m_ptr);
            end else if (release_i || !req[m_owner] || (m_hold == MH - 1)) begin
                others = req;
                others[m_owner] = 1'b0;
                winner = rr_pick(others, m_ptr);
                if (winner < 0 && req[m_owner]) winner = m_owner;
                if (winner < 0) begin
                    m_owner <= -1;
                    m_hold  <= 0;
                end
            end else begin
                m_hold <= (m_hold < MH - 1) ? m_hold + 1 : m_hold;
            end
            if (winner >= 0) begin
                m_owner <= winner;
                m_ptr   <= (winner + 1) % N;
                m_hold  <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the DUT with the model
    task automatic tick();
        logic [3:0] eg;
        @(negedge clk);
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("model_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("inv_idx_bit", 32'(!grant_valid || grant[grant_idx]), 32'd1);
    endtask

    logic [3:0] fair_seq [4];

    initial begin
        fair_seq[0] = 4'b0010;
        fair_seq[1] = 4'b0100;
        fair_seq[2] = 4'b1000;
        fair_seq[3] = 4'b0001;

        // Reset with all requesting
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_valid", 32'(grant_valid), 32'h0);
        chk("reset_idx", 32'(grant_idx), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_grant", 32'(grant), 32'h1);

        // Fairness: release two cycles after each grant
        foreach (fair_seq[k]) begin
            tick();
            chk("fair_no_bubble", 32'(grant_valid), 32'h1);
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            chk("fair_seq", 32'(grant), 32'(fair_seq[k]));
        end

        // Wrap: owner idx0, ptr=1
        req = 4'b0011;
        release_i = 1'b1;
        tick();
        chk("wrap_pre_idx1", 32'(grant), 32'h2);
        tick();
        chk("wrap_to_0", 32'(grant), 32'h1);
        tick();
        chk("wrap_then_1", 32'(grant), 32'h2);
        release_i = 1'b0;

        // Timeout: lone requester 2 is re-granted every MAX_HOLD cycles
        req = 4'b0100;
        tick();
        chk("to_grant2", 32'(grant), 32'h4);
        for (int i = 0; i < 4; i++) tick();
        chk("to_regrant2", 32'(grant), 32'h4);
        req = 4'b0101;
        for (int i = 0; i < 3; i++) tick();
        chk("to_still2", 32'(grant), 32'h4);
        tick();
        chk("to_handover0", 32'(grant), 32'h1);

        // Auto-release to idle, release in idle ignored
        req = 4'b1000;
        tick();
        chk("auto_grant3", 32'(grant), 32'h8);
        req = 4'b0000;
        tick();
        chk("auto_idle_grant", 32'(grant), 32'h0);
        chk("auto_idle_valid", 32'(grant_valid), 32'h0);
        release_i = 1'b1;
        tick();
        chk("idle_rel_ignored", 32'(grant), 32'h0);
        release_i = 1'b0;

        // Async reset between edges while owner idx2 holds the grant
        req = 4'b0100;
        tick();
        chk("ar_grant2", 32'(grant), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant_zero", 32'(grant), 32'h0);
        chk("ar_valid_zero", 32'(grant_valid), 32'h0);
        chk("ar_idx_zero", 32'(grant_idx), 32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'b1100;
        tick();
        chk("ar_ptr0_order", 32'(grant), 32'h4);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            tick();
            if ($urandom_range(2, 0) != 0) req = 4'($urandom);
            release_i = ($urandom_range(3, 0) == 0);
            rst_n     = ($urandom_range(149, 0) != 0);
        end
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
